// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the operational_memory access port between the CPU MEM stage (port 0)
// and the debug/program loader (port 1). Define ARB_STARVE_GUARD_EN to bound the debug port's wait.
module mem_access_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter bit RR         = 1'b0,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wren,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    input  logic          dbg_wren,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wren,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rden,
    input  logic [DW-1:0] mem_q
);

    logic w_dbg_win;
    logic w_grant;
    logic w_win_wren;
    logic w_force_dbg;
    logic r_last_gnt;
    logic r_rd_pend_p1;
    logic r_rd_owner_p1;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve_cnt;

    assign w_force_dbg = dbg_req && (r_starve_cnt == SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_dbg = 1'b0;
`endif

    // Winner select: 0 = CPU, 1 = debug; last_gnt=1 after reset so CPU goes first under RR
    always_comb begin
        w_dbg_win = 1'b0;
        if (w_force_dbg) begin
            w_dbg_win = 1'b1;
        end else if (dbg_req && !cpu_req) begin
            w_dbg_win = 1'b1;
        end else if (dbg_req && cpu_req && RR && !r_last_gnt) begin
            w_dbg_win = 1'b1;
        end
    end

    assign w_grant    = rst_n && (cpu_req || dbg_req);
    assign w_win_wren = w_dbg_win ? dbg_wren : cpu_wren;
    assign cpu_gnt    = w_grant && !w_dbg_win;
    assign dbg_gnt    = w_grant && w_dbg_win;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        mem_rden  = 1'b0;
        if (w_grant) begin
            mem_addr  = w_dbg_win ? dbg_addr : cpu_addr;
            mem_wdata = w_dbg_win ? dbg_wdata : cpu_wdata;
            mem_wren  = w_win_wren;
            mem_rden  = !w_win_wren;
        end
    end

    // Stage p0 -> p1: remember who issued a read so the returning mem_q is steered to it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt    <= 1'b1;
            r_rd_pend_p1  <= 1'b0;
            r_rd_owner_p1 <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_gnt <= w_dbg_win;
            end
            r_rd_pend_p1  <= w_grant && !w_win_wren;
            r_rd_owner_p1 <= w_dbg_win;
        end
    end

    // Gating with rst_n drops a read caught in flight by reset
    assign cpu_rvalid = rst_n && r_rd_pend_p1 && !r_rd_owner_p1;
    assign dbg_rvalid = rst_n && r_rd_pend_p1 && r_rd_owner_p1;
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_q : '0;

endmodule
